// File: rtl/tile_dispatcher.sv
// Double-buffered tile dispatcher: sequences tile rasterization in raster order and
// streams each finished tile into the framebuffer while the next tile is rasterized.
module tile_dispatcher #(
    parameter int tileDim      = 8,
    parameter int screenWidth  = 640,
    parameter int screenHeight = 480
) (
    input  logic                                  BOARD_CLK,
    input  logic                                  reset,
    input  logic                                  frameStart,
    output logic                                  busy,
    output logic                                  frameDone,
    output logic                                  startRasterizing,
    output logic                                  rasterTileID,
    output logic [9:0]                            rasterxOffset,
    output logic [9:0]                            rasteryOffset,
    input  logic                                  doneRasterizing,
    input  logic [tileDim-1:0][tileDim-1:0][15:0] cBufferTile0,
    input  logic [tileDim-1:0][tileDim-1:0][15:0] cBufferTile1,
    output logic                                  fbWriteEn,
    output logic [9:0]                            fbAddrX,
    output logic [9:0]                            fbAddrY,
    output logic [15:0]                           fbData,
    input  logic                                  fbReady
);

    localparam int cntW = (tileDim > 1) ? $clog2(tileDim) : 1;
    localparam logic [9:0] tileStep = 10'(tileDim);
    localparam logic [9:0] widthL   = 10'(screenWidth);
    localparam logic [9:0] lastX    = 10'(screenWidth - tileDim);
    localparam logic [9:0] lastY    = 10'(screenHeight - tileDim);
    localparam logic [cntW-1:0] lastIdx = cntW'(tileDim - 1);

    typedef enum logic [1:0] {IDLE, START, RELEASE, DRAIN} rasterState_t;
    typedef enum logic {WB_IDLE, WB_RUN} wbState_t;

    rasterState_t rasterState_r, rasterState_s;
    wbState_t     wbState_r, wbState_s;

    logic            busy_r, busy_s, frameDone_r, frameDone_s;
    logic            startRast_r, startRast_s, tileId_r, tileId_s;
    logic [9:0]      xOff_r, xOff_s, yOff_r, yOff_s;
    logic            lastHanded_r, lastHanded_s, handOff_s;
    logic            wbTile_r, wbTile_s;
    logic [9:0]      wbX_r, wbX_s, wbY_r, wbY_s;
    logic [cntW-1:0] col_r, col_s, row_r, row_s;
    logic            fbWriteEn_r, fbWriteEn_s;
    logic [9:0]      fbAddrX_r, fbAddrX_s, fbAddrY_r, fbAddrY_s;
    logic [15:0]     fbData_r, fbData_s;

    function automatic logic [15:0] pickPixel(
        input logic                                  sel,
        input logic [cntW-1:0]                       r,
        input logic [cntW-1:0]                       c,
        input logic [tileDim-1:0][tileDim-1:0][15:0] b0,
        input logic [tileDim-1:0][tileDim-1:0][15:0] b1
    );
        return sel ? b1[r][c] : b0[r][c];
    endfunction

    // Raster FSM next state; a request only rises while the rasterizer reports not-done.
    always_comb begin
        rasterState_s = rasterState_r;
        busy_s        = busy_r;
        frameDone_s   = 1'b0;
        startRast_s   = startRast_r;
        tileId_s      = tileId_r;
        xOff_s        = xOff_r;
        yOff_s        = yOff_r;
        lastHanded_s  = lastHanded_r;
        handOff_s     = 1'b0;
        case (rasterState_r)
            IDLE: begin
                if (frameStart) begin
                    busy_s        = 1'b1;
                    xOff_s        = 10'd0;
                    yOff_s        = 10'd0;
                    tileId_s      = 1'b0;
                    lastHanded_s  = 1'b0;
                    startRast_s   = ~doneRasterizing;
                    rasterState_s = START;
                end else begin
                    rasterState_s = IDLE;
                end
            end
            START: begin
                if (!startRast_r) begin
                    startRast_s = ~doneRasterizing;
                end else if (doneRasterizing && (wbState_r == WB_IDLE)) begin
                    handOff_s     = 1'b1;
                    startRast_s   = 1'b0;
                    tileId_s      = ~tileId_r;
                    lastHanded_s  = (xOff_r == lastX) && (yOff_r == lastY);
                    rasterState_s = RELEASE;
                    if ((xOff_r + tileStep) == widthL) begin
                        xOff_s = 10'd0;
                        yOff_s = yOff_r + tileStep;
                    end else begin
                        xOff_s = xOff_r + tileStep;
                    end
                end else begin
                    startRast_s = 1'b1;
                end
            end
            RELEASE: begin
                if (!doneRasterizing) begin
                    if (lastHanded_r) begin
                        rasterState_s = DRAIN;
                    end else begin
                        rasterState_s = START;
                        startRast_s   = 1'b1;
                    end
                end else begin
                    rasterState_s = RELEASE;
                end
            end
            DRAIN: begin
                if (wbState_r == WB_IDLE) begin
                    frameDone_s   = 1'b1;
                    busy_s        = 1'b0;
                    rasterState_s = IDLE;
                end else begin
                    rasterState_s = DRAIN;
                end
            end
            default: rasterState_s = IDLE;
        endcase
    end

    // Raster FSM state and its registered outputs.
    always_ff @(posedge BOARD_CLK or posedge reset) begin
        if (reset) begin
            rasterState_r <= IDLE;
            busy_r        <= 1'b0;
            frameDone_r   <= 1'b0;
            startRast_r   <= 1'b0;
            tileId_r      <= 1'b0;
            xOff_r        <= 10'd0;
            yOff_r        <= 10'd0;
            lastHanded_r  <= 1'b0;
        end else begin
            rasterState_r <= rasterState_s;
            busy_r        <= busy_s;
            frameDone_r   <= frameDone_s;
            startRast_r   <= startRast_s;
            tileId_r      <= tileId_s;
            xOff_r        <= xOff_s;
            yOff_r        <= yOff_s;
            lastHanded_r  <= lastHanded_s;
        end
    end

    // Writeback FSM next state; the first pixel is presented on the hand-off edge itself.
    always_comb begin
        wbState_s   = wbState_r;
        wbTile_s    = wbTile_r;
        wbX_s       = wbX_r;
        wbY_s       = wbY_r;
        col_s       = col_r;
        row_s       = row_r;
        fbWriteEn_s = fbWriteEn_r;
        fbAddrX_s   = fbAddrX_r;
        fbAddrY_s   = fbAddrY_r;
        fbData_s    = fbData_r;
        case (wbState_r)
            WB_IDLE: begin
                if (handOff_s) begin
                    wbState_s   = WB_RUN;
                    wbTile_s    = tileId_r;
                    wbX_s       = xOff_r;
                    wbY_s       = yOff_r;
                    col_s       = '0;
                    row_s       = '0;
                    fbWriteEn_s = 1'b1;
                    fbAddrX_s   = xOff_r;
                    fbAddrY_s   = yOff_r;
                    fbData_s    = pickPixel(tileId_r, '0, '0, cBufferTile0, cBufferTile1);
                end else begin
                    wbState_s = WB_IDLE;
                end
            end
            WB_RUN: begin
                if (fbReady) begin
                    if ((col_r == lastIdx) && (row_r == lastIdx)) begin
                        wbState_s   = WB_IDLE;
                        fbWriteEn_s = 1'b0;
                    end else begin
                        if (col_r == lastIdx) begin
                            col_s = '0;
                            row_s = row_r + cntW'(1);
                        end else begin
                            col_s = col_r + cntW'(1);
                        end
                        fbAddrX_s = wbX_r + 10'(col_s);
                        fbAddrY_s = wbY_r + 10'(row_s);
                        fbData_s  = pickPixel(wbTile_r, row_s, col_s, cBufferTile0, cBufferTile1);
                    end
                end else begin
                    wbState_s = WB_RUN;
                end
            end
            default: wbState_s = WB_IDLE;
        endcase
    end

    // Writeback FSM state, latched tile origin and framebuffer port registers.
    always_ff @(posedge BOARD_CLK or posedge reset) begin
        if (reset) begin
            wbState_r   <= WB_IDLE;
            wbTile_r    <= 1'b0;
            wbX_r       <= 10'd0;
            wbY_r       <= 10'd0;
            col_r       <= '0;
            row_r       <= '0;
            fbWriteEn_r <= 1'b0;
            fbAddrX_r   <= 10'd0;
            fbAddrY_r   <= 10'd0;
            fbData_r    <= 16'd0;
        end else begin
            wbState_r   <= wbState_s;
            wbTile_r    <= wbTile_s;
            wbX_r       <= wbX_s;
            wbY_r       <= wbY_s;
            col_r       <= col_s;
            row_r       <= row_s;
            fbWriteEn_r <= fbWriteEn_s;
            fbAddrX_r   <= fbAddrX_s;
            fbAddrY_r   <= fbAddrY_s;
            fbData_r    <= fbData_s;
        end
    end

    assign busy             = busy_r;
    assign frameDone        = frameDone_r;
    assign startRasterizing = startRast_r;
    assign rasterTileID     = tileId_r;
    assign rasterxOffset    = xOff_r;
    assign rasteryOffset    = yOff_r;
    assign fbWriteEn        = fbWriteEn_r;
    assign fbAddrX          = fbAddrX_r;
    assign fbAddrY          = fbAddrY_r;
    assign fbData           = fbData_r;

endmodule
